// File: rtl/settings_sequencer.sv
// settings_sequencer
// Plays the x/i/fi setpoint tables to the regulator datapath. The table index
// steps from START_IDX to END_IDX (wrapping modulo the table depth). Each
// entry is held for max(DWELL,1)+2 cycles. Playback can optionally loop.
// Point mode drives the fixed point setpoints instead and aborts playback.
// The block has its own small register slave and a read port into the
// shared setpoint table RAM.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no playback; outputs hold, or follow points when POINT=1
// FETCH | tbl_rd asserted for one cycle with tbl_addr = idx
// LOAD  | table data valid; latched into the setpoint outputs
// HOLD  | dwell countdown; on expiry step, loop or finish
module settings_sequencer #(
  parameter int WIDTH_SET = 16,
  parameter int ADDR_W    = 8,
  parameter int DWELL_W   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             address,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic                   write,
  input  logic                   read,
  output logic                   tbl_rd,
  output logic [ADDR_W-1:0]      tbl_addr,
  input  logic [2*WIDTH_SET-1:0] tbl_x,
  input  logic [2*WIDTH_SET-1:0] tbl_i,
  input  logic [2*WIDTH_SET-1:0] tbl_fi,
  output logic [2*WIDTH_SET-1:0] x_set,
  output logic [2*WIDTH_SET-1:0] i_set,
  output logic [2*WIDTH_SET-1:0] fi_set,
  output logic                   set_strobe,
  output logic                   busy,
  output logic                   irq_done
);

  localparam int SW = 2 * WIDTH_SET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0]  start_idx_q, start_idx_d;
  logic [ADDR_W-1:0]  end_idx_q, end_idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_m1;
  logic               loop_q, loop_d;
  logic               point_q, point_d;
  logic               done_q, done_d;
  logic               addr_err_q, addr_err_d;
  logic [SW-1:0]      x_pt_q, x_pt_d;
  logic [SW-1:0]      i_pt_q, i_pt_d;
  logic [SW-1:0]      fi_pt_q, fi_pt_d;

  logic [SW-1:0]      x_set_q, x_set_d;
  logic [SW-1:0]      i_set_q, i_set_d;
  logic [SW-1:0]      fi_set_q, fi_set_d;
  logic               set_strobe_q, set_strobe_d;
  logic               irq_done_q, irq_done_d;
  logic [31:0]        readdata_q, readdata_d;
  logic [31:0]        rd_word;

  logic wr_ctrl, wr_start_idx, wr_end_idx, wr_dwell;
  logic wr_x_pt, wr_i_pt, wr_fi_pt, wr_status, wr_unmapped, wr_point_any;
  logic start_cmd, abort_cmd, pt_strobe;
  logic load_tbl, done_set;

  // Register write decode
  assign wr_ctrl      = write && (address == 4'd0);
  assign wr_start_idx = write && (address == 4'd1);
  assign wr_end_idx   = write && (address == 4'd2);
  assign wr_dwell     = write && (address == 4'd3);
  assign wr_x_pt      = write && (address == 4'd4);
  assign wr_i_pt      = write && (address == 4'd5);
  assign wr_fi_pt     = write && (address == 4'd6);
  assign wr_status    = write && (address == 4'd7);
  assign wr_unmapped  = write && address[3];
  assign wr_point_any = wr_x_pt || wr_i_pt || wr_fi_pt;

  // STOP beats START in the same write; START is ignored whenever point mode
  // is on or being turned on by the same write.
  assign abort_cmd = wr_ctrl && (writedata[1] || writedata[3]);
  assign start_cmd = wr_ctrl && writedata[0] && !writedata[1]
                     && !writedata[3] && !point_q;

  // A new point value reaches the outputs together with its strobe.
  assign pt_strobe = (point_d && !point_q) || (point_q && wr_point_any);

  // Zero dwell behaves like a dwell of one cycle.
  assign dwell_m1 = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: abort first, then restart, then normal sequencing
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    load_tbl = 1'b0;
    done_set = 1'b0;
    if (abort_cmd) begin
      state_d = IDLE;
    end else if (start_cmd) begin
      state_d = FETCH;
      idx_d   = start_idx_q;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FETCH: begin
          state_d = LOAD;
        end
        LOAD: begin
          load_tbl = 1'b1;
          cnt_d    = dwell_m1;
          state_d  = HOLD;
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (idx_q != end_idx_q) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end else if (loop_q) begin
            idx_d   = start_idx_q;
            state_d = FETCH;
          end else begin
            done_set = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Register file next values, including sticky status bits
  always_comb begin
    loop_d      = loop_q;
    point_d     = point_q;
    start_idx_d = start_idx_q;
    end_idx_d   = end_idx_q;
    dwell_d     = dwell_q;
    x_pt_d      = x_pt_q;
    i_pt_d      = i_pt_q;
    fi_pt_d     = fi_pt_q;
    done_d      = done_q;
    addr_err_d  = addr_err_q;
    if (wr_ctrl) begin
      loop_d  = writedata[2];
      point_d = writedata[3];
    end
    if (wr_start_idx) start_idx_d = writedata[ADDR_W-1:0];
    if (wr_end_idx)   end_idx_d   = writedata[ADDR_W-1:0];
    if (wr_dwell)     dwell_d     = writedata[DWELL_W-1:0];
    if (wr_x_pt)      x_pt_d      = writedata[SW-1:0];
    if (wr_i_pt)      i_pt_d      = writedata[SW-1:0];
    if (wr_fi_pt)     fi_pt_d     = writedata[SW-1:0];
    if (start_cmd || (wr_status && writedata[1])) done_d = 1'b0;
    if (done_set) done_d = 1'b1;
    if (wr_status && writedata[2]) addr_err_d = 1'b0;
    if (wr_unmapped) addr_err_d = 1'b1;
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_q      <= 1'b0;
      point_q     <= 1'b0;
      start_idx_q <= '0;
      end_idx_q   <= '0;
      dwell_q     <= '0;
      x_pt_q      <= '0;
      i_pt_q      <= '0;
      fi_pt_q     <= '0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      loop_q      <= loop_d;
      point_q     <= point_d;
      start_idx_q <= start_idx_d;
      end_idx_q   <= end_idx_d;
      dwell_q     <= dwell_d;
      x_pt_q      <= x_pt_d;
      i_pt_q      <= i_pt_d;
      fi_pt_q     <= fi_pt_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Read mux; unmapped addresses and unused bits read as zero
  always_comb begin
    rd_word = '0;
    case (address)
      4'd0: begin
        rd_word[2] = loop_q;
        rd_word[3] = point_q;
      end
      4'd1: rd_word[ADDR_W-1:0]  = start_idx_q;
      4'd2: rd_word[ADDR_W-1:0]  = end_idx_q;
      4'd3: rd_word[DWELL_W-1:0] = dwell_q;
      4'd4: rd_word[SW-1:0]      = x_pt_q;
      4'd5: rd_word[SW-1:0]      = i_pt_q;
      4'd6: rd_word[SW-1:0]      = fi_pt_q;
      4'd7: begin
        rd_word[0]          = busy;
        rd_word[1]          = done_q;
        rd_word[2]          = addr_err_q;
        rd_word[8 +: ADDR_W] = idx_q;
      end
      default: rd_word = '0;
    endcase
  end

  // Output next values: point mode overrides table loads
  always_comb begin
    x_set_d      = x_set_q;
    i_set_d      = i_set_q;
    fi_set_d     = fi_set_q;
    set_strobe_d = load_tbl || pt_strobe;
    irq_done_d   = done_set;
    readdata_d   = (read && !write) ? rd_word : readdata_q;
    if (point_d) begin
      x_set_d  = x_pt_d;
      i_set_d  = i_pt_d;
      fi_set_d = fi_pt_d;
    end else if (load_tbl) begin
      x_set_d  = tbl_x;
      i_set_d  = tbl_i;
      fi_set_d = tbl_fi;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_set_q      <= '0;
      i_set_q      <= '0;
      fi_set_q     <= '0;
      set_strobe_q <= 1'b0;
      irq_done_q   <= 1'b0;
      readdata_q   <= '0;
    end else begin
      x_set_q      <= x_set_d;
      i_set_q      <= i_set_d;
      fi_set_q     <= fi_set_d;
      set_strobe_q <= set_strobe_d;
      irq_done_q   <= irq_done_d;
      readdata_q   <= readdata_d;
    end
  end

  // The table read is gated by rst so it drops in the same cycle reset rises.
  assign tbl_rd     = (state_q == FETCH) && !rst;
  assign tbl_addr   = tbl_rd ? idx_q : '0;
  assign busy       = (state_q != IDLE);
  assign x_set      = x_set_q;
  assign i_set      = i_set_q;
  assign fi_set     = fi_set_q;
  assign set_strobe = set_strobe_q;
  assign irq_done   = irq_done_q;
  assign readdata   = readdata_q;

endmodule

// File: tb/tb_settings_sequencer.sv
// Testbench for settings_sequencer: randomized and directed playbacks checked
// cycle by cycle against a timeline computed from step arithmetic.
module tb_settings_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        write;
  logic        read;
  logic        tbl_rd;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_x = '0;
  logic [31:0] tbl_i = '0;
  logic [31:0] tbl_fi = '0;
  logic [31:0] x_set, i_set, fi_set;
  logic        set_strobe, busy, irq_done;

  int n_checks = 0;
  int n_fail   = 0;

  // expected state of the block
  logic [31:0] m_x, m_i, m_fi;
  bit          m_done, m_err;
  int          m_idx;

  always #5 clk = ~clk;

  settings_sequencer #(.WIDTH_SET(16), .ADDR_W(8), .DWELL_W(24)) dut (
    .clk(clk), .rst(rst), .address(address), .writedata(writedata),
    .readdata(readdata), .write(write), .read(read),
    .tbl_rd(tbl_rd), .tbl_addr(tbl_addr),
    .tbl_x(tbl_x), .tbl_i(tbl_i), .tbl_fi(tbl_fi),
    .x_set(x_set), .i_set(i_set), .fi_set(fi_set),
    .set_strobe(set_strobe), .busy(busy), .irq_done(irq_done)
  );

  function automatic logic [31:0] fx(int a);
    return 32'h100 + 32'(a);
  endfunction
  function automatic logic [31:0] fi(int a);
    return 32'h0002_0000 + 32'(a) * 32'd7;
  endfunction
  function automatic logic [31:0] ffi(int a);
    return 32'hF000_0000 ^ (32'(a) << 8);
  endfunction

  // setpoint table RAM: one cycle read latency
  always @(posedge clk) begin
    if (tbl_rd) begin
      tbl_x  <= fx(int'(tbl_addr));
      tbl_i  <= fi(int'(tbl_addr));
      tbl_fi <= ffi(int'(tbl_addr));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_exp(bit b);
    return (32'(m_idx & 255) << 8) | (32'(m_err) << 2) | (32'(m_done) << 1) | 32'(b);
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic check_outs();
    check_val("x_set", x_set, m_x);
    check_val("i_set", i_set, m_i);
    check_val("fi_set", fi_set, m_fi);
  endtask

  // n cycles with no playback: nothing moves, outputs hold
  task automatic check_idle_for(input int n);
    for (int c = 0; c < n; c++) begin
      check_val("idle_tbl_rd", 32'(tbl_rd), 32'd0);
      check_val("idle_strobe", 32'(set_strobe), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_irq", 32'(irq_done), 32'd0);
      check_outs();
      if (c != n - 1) @(negedge clk);
    end
  endtask

  // Called at the negedge of the first cycle after START was sampled.
  // Step s occupies cycles [s*P, s*P+P) with P = max(dwell,1)+2: fetch at
  // offset 0, new setpoints and strobe from offset 2.
  task automatic run_playback(input int st, input int en, input int dw,
                              input bit lp, input int ncyc);
    int d, p, len, total, s, ph, idx;
    d     = (dw == 0) ? 1 : dw;
    p     = d + 2;
    len   = ((en - st + 256) % 256) + 1;
    total = lp ? 32'h3FFF_FFFF : len * p;
    m_done = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      if (n < total) begin
        s   = n / p;
        ph  = n % p;
        idx = (st + (lp ? (s % len) : s)) % 256;
        m_idx = idx;
        if (ph == 2) begin
          m_x = fx(idx); m_i = fi(idx); m_fi = ffi(idx);
        end
        check_val("tbl_rd", 32'(tbl_rd), 32'(ph == 0));
        check_val("tbl_addr", 32'(tbl_addr), (ph == 0) ? 32'(idx) : 32'd0);
        check_val("set_strobe", 32'(set_strobe), 32'(ph == 2));
        check_val("busy", 32'(busy), 32'd1);
        check_val("irq_done", 32'(irq_done), 32'd0);
      end else begin
        if (n == total) m_done = 1'b1;
        check_val("end_tbl_rd", 32'(tbl_rd), 32'd0);
        check_val("end_strobe", 32'(set_strobe), 32'd0);
        check_val("end_busy", 32'(busy), 32'd0);
        check_val("end_irq", 32'(irq_done), 32'(n == total));
      end
      check_outs();
      if (n != ncyc - 1) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd, prev;
    int st, len, en, dw, d;

    rst = 1'b1; address = '0; writedata = '0; write = 1'b0; read = 1'b0;
    m_x = '0; m_i = '0; m_fi = '0; m_done = 1'b0; m_err = 1'b0; m_idx = 0;

    // reset
    repeat (2) @(negedge clk);
    check_idle_for(1);
    check_val("rst_readdata", readdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_for(1);
    bus_read(4'd7, rd); check_val("rst_status", rd, 32'd0);
    bus_read(4'd0, rd); check_val("rst_ctrl", rd, 32'd0);

    // basic playback 2..4, dwell 3
    bus_write(4'd1, 32'd2);
    bus_write(4'd2, 32'd4);
    bus_write(4'd3, 32'd3);
    bus_write(4'd0, 32'h1);
    run_playback(2, 4, 3, 1'b0, 3 * 5 + 3);
    bus_read(4'd7, rd); check_val("basic_status", rd, status_exp(1'b0));

    // randomized single-pass playbacks, half of them around the index wrap
    for (int k = 0; k < 6; k++) begin
      st  = (k % 2 == 1) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 255));
      len = int'($urandom_range(1, 5));
      en  = (st + len - 1) % 256;
      dw  = int'($urandom_range(0, 4));
      d   = (dw == 0) ? 1 : dw;
      bus_write(4'd1, 32'(st));
      bus_write(4'd2, 32'(en));
      bus_write(4'd3, 32'(dw));
      bus_write(4'd0, 32'h1);
      run_playback(st, en, dw, 1'b0, len * (d + 2) + 2);
      bus_read(4'd7, rd); check_val("rand_status", rd, status_exp(1'b0));
    end

    // loop across the wrap, dwell 0, then STOP
    bus_write(4'd1, 32'hFE);
    bus_write(4'd2, 32'h01);
    bus_write(4'd3, 32'h0);
    bus_write(4'd0, 32'h5);
    run_playback(8'hFE, 8'h01, 0, 1'b1, 24);
    bus_write(4'd0, 32'h2);
    check_idle_for(3);
    bus_read(4'd7, rd); check_val("stop_status", rd, status_exp(1'b0));

    // register bus behaviour
    bus_write(4'd9, 32'hFFFF_FFFF);
    m_err = 1'b1;
    bus_read(4'd7, rd); check_val("addr_err_set", rd, status_exp(1'b0));
    bus_write(4'd7, 32'h4);
    m_err = 1'b0;
    bus_read(4'd7, rd); check_val("addr_err_w1c", rd, status_exp(1'b0));
    bus_read(4'd12, rd); check_val("unmapped_read", rd, 32'd0);
    bus_write(4'd0, 32'h3);
    check_idle_for(4);
    bus_write(4'd0, 32'h7);
    check_idle_for(3);
    bus_read(4'd0, rd); check_val("ctrl_readback", rd, 32'h4);
    bus_write(4'd1, 32'hFFFF_FFFF);
    bus_read(4'd1, rd); check_val("start_idx_mask", rd, 32'hFF);
    bus_write(4'd3, 32'hFFFF_FFFF);
    bus_read(4'd3, rd); check_val("dwell_mask", rd, 32'h00FF_FFFF);
    bus_read(4'd2, rd); check_val("end_idx_read", rd, 32'h01);
    prev = rd;
    address = 4'd1; writedata = 32'h55; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    check_val("wr_rd_hold", readdata, prev);
    bus_read(4'd1, rd); check_val("wr_rd_written", rd, 32'h55);
    bus_write(4'd0, 32'h0);

    // point mode
    bus_write(4'd4, 32'hDEAD_0001);
    check_idle_for(1);
    bus_write(4'd5, 32'h1111_2222);
    bus_write(4'd6, 32'h3333_4444);
    bus_write(4'd1, 32'd10);
    bus_write(4'd2, 32'd12);
    bus_write(4'd3, 32'd2);
    bus_write(4'd0, 32'h5);
    run_playback(10, 12, 2, 1'b1, 7);
    bus_write(4'd0, 32'hC);
    m_x = 32'hDEAD_0001; m_i = 32'h1111_2222; m_fi = 32'h3333_4444;
    check_val("pt_busy", 32'(busy), 32'd0);
    check_val("pt_strobe", 32'(set_strobe), 32'd1);
    check_val("pt_tbl_rd", 32'(tbl_rd), 32'd0);
    check_outs();
    @(negedge clk);
    check_idle_for(1);
    bus_write(4'd0, 32'hD);
    check_idle_for(4);
    bus_write(4'd4, 32'h1234_5678);
    m_x = 32'h1234_5678;
    check_val("pt_wr_strobe", 32'(set_strobe), 32'd1);
    check_outs();
    @(negedge clk);
    check_idle_for(1);
    bus_write(4'd0, 32'h0);
    check_idle_for(2);
    bus_read(4'd0, rd); check_val("pt_off_ctrl", rd, 32'h0);

    // restart while holding index 3
    bus_write(4'd1, 32'd2);
    bus_write(4'd2, 32'd6);
    bus_write(4'd3, 32'd2);
    bus_write(4'd0, 32'h1);
    run_playback(2, 6, 2, 1'b0, 7);
    bus_write(4'd0, 32'h1);
    run_playback(2, 6, 2, 1'b0, 22);
    bus_read(4'd7, rd); check_val("restart_status", rd, status_exp(1'b0));
    bus_write(4'd7, 32'h2);
    m_done = 1'b0;
    bus_read(4'd7, rd); check_val("done_w1c", rd, status_exp(1'b0));

    // reset in the middle of HOLD
    bus_write(4'd0, 32'h1);
    run_playback(2, 6, 2, 1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    m_x = '0; m_i = '0; m_fi = '0; m_done = 1'b0; m_err = 1'b0; m_idx = 0;
    check_idle_for(1);
    rst = 1'b0;
    @(negedge clk);
    check_idle_for(1);
    bus_read(4'd1, rd); check_val("rst_start_idx", rd, 32'd0);
    bus_read(4'd3, rd); check_val("rst_dwell", rd, 32'd0);

    // reset during FETCH drops the table read at once
    bus_write(4'd0, 32'h1);
    run_playback(0, 0, 0, 1'b0, 1);
    rst = 1'b1;
    #1;
    check_val("rst_tbl_rd_now", 32'(tbl_rd), 32'd0);
    @(negedge clk);
    check_idle_for(1);
    rst = 1'b0;
    @(negedge clk);
    bus_read(4'd7, rd); check_val("final_status", rd, status_exp(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
